// File: rtl/mux8_bus_arbiter.sv
// Round-robin arbiter for the shared 8:1 result bus, with a per-grant burst limit.
// Define MUX8_ARB_FIXED_PRIO_EN to replace round-robin with fixed priority (req[0] highest).
module mux8_bus_arbiter #(
    parameter int MAX_BURST = 4,
    parameter int DATA_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        req,
    input  logic [DATA_W-1:0] data0,
    input  logic [DATA_W-1:0] data1,
    input  logic [DATA_W-1:0] data2,
    input  logic [DATA_W-1:0] data3,
    input  logic [DATA_W-1:0] data4,
    input  logic [DATA_W-1:0] data5,
    input  logic [DATA_W-1:0] data6,
    input  logic [DATA_W-1:0] data7,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [2:0]        select,
    output logic [7:0]        grant,
    output logic              busy
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t           state, state_nxt;
    logic [2:0]       select_nxt;
    logic [7:0]       grant_nxt;
    logic [CNT_W-1:0] beat_cnt, beat_cnt_nxt;
    logic [2:0]       winner;
    logic             found;

`ifndef MUX8_ARB_FIXED_PRIO_EN
    logic [2:0] rr_ptr, rr_ptr_nxt;
    logic [2:0] scan_idx;
`endif

    // Pick the next requester to grant from the current request vector.
    always_comb begin
        winner = 3'd0;
        found  = 1'b0;
`ifdef MUX8_ARB_FIXED_PRIO_EN
        // Scanning downward leaves the lowest set index as the winner.
        for (int i = 7; i >= 0; i--) begin
            if (req[i]) begin
                winner = 3'(i);
                found  = 1'b1;
            end
        end
`else
        scan_idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            scan_idx = rr_ptr + 3'(i);
            if (!found && req[scan_idx]) begin
                winner = scan_idx;
                found  = 1'b1;
            end
        end
`endif
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_nxt    = state;
        select_nxt   = select;
        grant_nxt    = grant;
        beat_cnt_nxt = beat_cnt;
`ifndef MUX8_ARB_FIXED_PRIO_EN
        rr_ptr_nxt   = rr_ptr;
`endif
        case (state)
            IDLE: begin
                if (found) begin
                    state_nxt    = GRANT;
                    select_nxt   = winner;
                    grant_nxt    = 8'b1 << winner;
                    beat_cnt_nxt = '0;
                end
            end
            GRANT: begin
                if (!req[select] || (out_ready && beat_cnt == LAST_BEAT)) begin
                    state_nxt  = IDLE;
                    grant_nxt  = 8'd0;
`ifndef MUX8_ARB_FIXED_PRIO_EN
                    rr_ptr_nxt = select + 3'd1;
`endif
                end else if (out_ready) begin
                    beat_cnt_nxt = beat_cnt + CNT_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            select   <= 3'd0;
            grant    <= 8'd0;
            beat_cnt <= '0;
`ifndef MUX8_ARB_FIXED_PRIO_EN
            rr_ptr   <= 3'd0;
`endif
        end else begin
            state    <= state_nxt;
            select   <= select_nxt;
            grant    <= grant_nxt;
            beat_cnt <= beat_cnt_nxt;
`ifndef MUX8_ARB_FIXED_PRIO_EN
            rr_ptr   <= rr_ptr_nxt;
`endif
        end
    end

    assign busy      = (state == GRANT);
    // Combinational so a dropped request withdraws the beat in the same cycle.
    assign out_valid = busy && req[select];

    always_comb begin
        case (select)
            3'd0:    out_data = data0;
            3'd1:    out_data = data1;
            3'd2:    out_data = data2;
            3'd3:    out_data = data3;
            3'd4:    out_data = data4;
            3'd5:    out_data = data5;
            3'd6:    out_data = data6;
            default: out_data = data7;
        endcase
    end

endmodule

// File: tb/tb_mux8_bus_arbiter.sv
// Directed, table-driven bench for mux8_bus_arbiter (MAX_BURST=4, DATA_W=32).
// Build with MUX8_ARB_FIXED_PRIO_EN defined to exercise the fixed-priority variant.
module tb_mux8_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  req;
    logic [31:0] data [8];
    logic        out_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic [2:0]  select;
    logic [7:0]  grant;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mux8_bus_arbiter #(.MAX_BURST(4), .DATA_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .data0     (data[0]),
        .data1     (data[1]),
        .data2     (data[2]),
        .data3     (data[3]),
        .data4     (data[4]),
        .data5     (data[5]),
        .data6     (data[6]),
        .data7     (data[7]),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .select    (select),
        .grant     (grant),
        .busy      (busy)
    );

    typedef struct {
        logic       rst;
        logic [7:0] req;
        logic       rdy;
        logic [7:0] exp_grant;
        logic [2:0] exp_sel;
        logic       exp_busy;
        logic       exp_valid;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic void add(input logic rst, input logic [7:0] r, input logic rdy,
                                input logic [7:0] g, input logic [2:0] s,
                                input logic b, input logic v);
        vec_t x;
        x.rst = rst; x.req = r; x.rdy = rdy;
        x.exp_grant = g; x.exp_sel = s; x.exp_busy = b; x.exp_valid = v;
        vecs.push_back(x);
    endfunction

    // Outputs seen in the current cycle; select and data only matter while granted.
    task automatic check_cycle(input string tag, input logic [7:0] g, input logic [2:0] s,
                               input logic b, input logic v);
        check({tag, ".grant"}, 32'(grant), 32'(g));
        check({tag, ".busy"}, 32'(busy), 32'(b));
        check({tag, ".valid"}, 32'(out_valid), 32'(v));
        if (b) begin
            check({tag, ".select"}, 32'(select), 32'(s));
            check({tag, ".data"}, out_data, 32'hA000_0000 + 32'(s));
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) data[i] = 32'hA000_0000 + 32'(i);
        reset     = 1'b1;
        req       = 8'h00;
        out_ready = 1'b1;

        // Reset state, with requests present to show reset dominates.
        repeat (2) @(posedge clk);
        @(negedge clk);
        req = 8'hFF;
        #1;
        check("reset.grant", 32'(grant), 32'h0);
        check("reset.busy", 32'(busy), 32'h0);
        check("reset.valid", 32'(out_valid), 32'h0);
        check("reset.select", 32'(select), 32'h0);
        check("reset.data", out_data, 32'hA000_0000);
        @(negedge clk);
        reset = 1'b0;
        req   = 8'h00;
        #1;
        check_cycle("post_reset", 8'h00, 3'd0, 1'b0, 1'b0);

`ifdef MUX8_ARB_FIXED_PRIO_EN
        // 4 wins over 5..7; req[1] raised mid-burst wins the next arbitration.
        add(0, 8'hF0, 1, 8'h00, 0, 0, 0);
        add(0, 8'hF0, 1, 8'h10, 4, 1, 1);
        add(0, 8'hF2, 1, 8'h10, 4, 1, 1);
        add(0, 8'hF2, 1, 8'h10, 4, 1, 1);
        add(0, 8'hF2, 1, 8'h10, 4, 1, 1);
        add(0, 8'hF2, 1, 8'h00, 0, 0, 0);
        add(0, 8'hF2, 1, 8'h02, 1, 1, 1);
        add(0, 8'hF0, 1, 8'h02, 1, 1, 0);
        add(0, 8'hF0, 1, 8'h00, 0, 0, 0);
        for (int i = 0; i < 4; i++) add(0, 8'hF0, 1, 8'h10, 4, 1, 1);
        add(0, 8'hF0, 1, 8'h00, 0, 0, 0);
        add(0, 8'hF0, 1, 8'h10, 4, 1, 1);
`else
        // Reset mid-burst on requester 3, then regrant 3 from rr_ptr=0.
        add(0, 8'h08, 1, 8'h00, 0, 0, 0);
        add(0, 8'h08, 1, 8'h08, 3, 1, 1);
        add(0, 8'h08, 1, 8'h08, 3, 1, 1);
        add(1, 8'h08, 1, 8'h08, 3, 1, 1);
        add(0, 8'h08, 1, 8'h00, 0, 0, 0);
        add(0, 8'h00, 1, 8'h08, 3, 1, 0);
        add(0, 8'h00, 1, 8'h00, 0, 0, 0);
        // Early release of 5 after two beats; rr_ptr=6 so 8'h21 grants 0.
        add(0, 8'h20, 1, 8'h00, 0, 0, 0);
        add(0, 8'h20, 1, 8'h20, 5, 1, 1);
        add(0, 8'h20, 1, 8'h20, 5, 1, 1);
        add(0, 8'h00, 1, 8'h20, 5, 1, 0);
        add(0, 8'h21, 1, 8'h00, 0, 0, 0);
        add(0, 8'h00, 0, 8'h01, 0, 1, 0);
        // Back-pressure on 2 for 10 cycles, then exactly 4 beats and one idle cycle.
        add(0, 8'h04, 0, 8'h00, 0, 0, 0);
        for (int i = 0; i < 10; i++) add(0, 8'h04, 0, 8'h04, 2, 1, 1);
        for (int i = 0; i < 4; i++)  add(0, 8'h04, 1, 8'h04, 2, 1, 1);
        add(0, 8'h04, 1, 8'h00, 0, 0, 0);
        add(0, 8'h00, 1, 8'h04, 2, 1, 0);
        // Wrap-around: grant 6 so rr_ptr=7, then 8'h81 grants 7, then 0.
        add(0, 8'h40, 1, 8'h00, 0, 0, 0);
        add(0, 8'h00, 1, 8'h40, 6, 1, 0);
        add(0, 8'h81, 1, 8'h00, 0, 0, 0);
        add(0, 8'h01, 1, 8'h80, 7, 1, 0);
        add(0, 8'h81, 1, 8'h00, 0, 0, 0);
        add(0, 8'h81, 1, 8'h01, 0, 1, 1);
`endif

        foreach (vecs[k]) begin
            @(negedge clk);
            reset     = vecs[k].rst;
            req       = vecs[k].req;
            out_ready = vecs[k].rdy;
            #1;
            check_cycle($sformatf("vec%0d", k), vecs[k].exp_grant, vecs[k].exp_sel,
                        vecs[k].exp_busy, vecs[k].exp_valid);
        end

`ifndef MUX8_ARB_FIXED_PRIO_EN
        // Fairness: all requesting, grants rotate 0..7,0 with 4 beats and 1 idle cycle each.
        @(negedge clk);
        reset = 1'b1;
        req   = 8'h00;
        @(negedge clk);
        reset     = 1'b0;
        req       = 8'hFF;
        out_ready = 1'b1;
        #1;
        check_cycle("rr.idle_start", 8'h00, 3'd0, 1'b0, 1'b0);
        for (int g = 0; g < 9; g++) begin
            for (int b = 0; b < 4; b++) begin
                @(negedge clk);
                #1;
                check_cycle($sformatf("rr.g%0d.b%0d", g, b), 8'h01 << (g % 8), 3'(g % 8), 1'b1, 1'b1);
            end
            @(negedge clk);
            #1;
            check_cycle($sformatf("rr.g%0d.idle", g), 8'h00, 3'd0, 1'b0, 1'b0);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mux8_bus_arbiter.md
Name: mux8_bus_arbiter

Overview:
- Round-robin arbiter that shares one 32-bit result bus among 8 requesters.
- Drives the 3-bit select of the existing 8:1 32-bit mux and a one-hot grant vector.
- Presents the selected source on a valid/ready output port, with a per-grant burst limit for fairness.
- Sits between the execution/memory producers and the shared writeback/forwarding bus.

Parameters:
- MAX_BURST, 4, maximum accepted beats per grant before forced release; legal range 1..255.
- DATA_W, 32, width of each data input and of out_data.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- req  input  8  per-requester request; bit i pairs with data_i.
- data0..data7  input  DATA_W each  requester payloads, fed to the 8:1 mux.
- out_ready  input  1  downstream accepts a beat this cycle.
- out_valid  output  1  out_data holds a valid beat.
- out_data  output  DATA_W  mux output for the current select.
- select  output  3  index of the granted requester, driving the mux select.
- grant  output  8  one-hot grant; all zero when idle.
- busy  output  1  high in GRANT state.

Behaviour:
- Reset: everything below is synchronous to clk, active-high.
  - state=IDLE, select=0, grant=0, busy=0, out_valid=0, rr_ptr=0, beat_cnt=0.
  - out_data equals data0 (select=0) but is don't-care while out_valid=0.
  - Reset asserted mid-grant aborts the burst at that edge; no beat is counted for that cycle.
- States: IDLE, GRANT.
- IDLE:
  - If req==0, stay.
  - Otherwise choose the first set bit scanning rr_ptr, rr_ptr+1, ..., wrapping mod 8.
  - At the next edge: select=winner, grant=1<<winner, beat_cnt=0, state=GRANT.
  - Request-to-grant latency is 1 cycle.
- GRANT:
  - out_valid = req[select], combinational, so a dropped request deasserts valid in the same cycle.
  - out_data = mux(select), combinational.
  - A beat occurs on an edge where out_valid && out_ready; beat_cnt increments.
- Release, both cases at the same edge:
  - Condition (a): req[select]==0 is sampled at an edge.
  - Condition (b): a beat occurs with beat_cnt==MAX_BURST-1, i.e. the MAX_BURST-th beat.
  - Action: state=IDLE, grant=0, rr_ptr=select+1 (3-bit wrap, 7 -> 0).
- Turnaround: one IDLE cycle always separates consecutive grants, including re-granting the same requester.
- Back-pressure: out_ready=0 holds the grant indefinitely. beat_cnt does not advance and the burst limit is not reached.
- Data stability: producers must hold data_i stable while req[i]=1 and no beat occurs. The arbiter does not register data.
- Non-granted req bits are ignored in GRANT; they are re-evaluated at the next IDLE cycle.
- beat_cnt width is $clog2(MAX_BURST+1). No other arithmetic.
- Invariants:
  - grant is zero or one-hot.
  - grant[select] = busy.
  - out_valid=0 whenever busy=0.

Optional Feature:
- Macro: MUX8_ARB_FIXED_PRIO_EN.
- Defined:
  - IDLE picks the lowest-index set req bit (req[0] highest priority).
  - rr_ptr is not implemented and is not updated.
  - Burst limit and all other behaviour are unchanged.
- Undefined: round-robin as specified above.

Test Plan:
- Reset mid-burst: grant requester 3, take 2 beats, assert reset 1 cycle -> next cycle grant=0, busy=0, out_valid=0. With req[3] still held, first IDLE evaluation regrants 3 (rr_ptr=0, scan 0..7, no lower bit set).
- Round-robin fairness: req=8'hFF held, out_ready=1, MAX_BURST=4 -> grants in order 0,1,...,7,0. Each grant carries exactly 4 beats then 1 IDLE cycle; out_data matches data_i (e.g. data_i=32'hA000_0000+i).
- Early release: grant 5, out_ready=1, drop req[5] after 2 beats -> out_valid low the same cycle, IDLE next edge, rr_ptr=6. req=8'h21 then grants 0 (scan 6,7,0).
- Back-pressure: grant 2, out_ready=0 for 10 cycles -> grant stays 8'h04, beat_cnt=0. Then out_ready=1 -> exactly 4 beats, then release.
- Wrap-around: rr_ptr=7 (after granting 6), req=8'h81 -> grant 7. After release, req=8'h81 -> grant 0.
- MUX8_ARB_FIXED_PRIO_EN defined, req=8'hF0 then req[1] raised during the grant to 4 -> after 4's burst, 1 wins. With req=8'hF0 only, 4 wins again each time.
